// File: rtl/sramlike_bridge_if.sv
// sramlike_bridge_if: sram-like request/response bus between the bridge and the interconnect
interface sramlike_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sramlike_bridge.sv
// sramlike_bridge: turns a single-cycle SRAM-style CPU port into a stallable sram-like bus master
module sramlike_bridge #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  bit MAP_EN = 1'b1,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 cpu_en,
    input  logic [STRB_W-1:0]    cpu_wen,
    input  logic [1:0]           cpu_size,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    input  logic                 cpu_hold,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_stall,
    sramlike_bridge_if.master    bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] paddr;

    if (MAP_EN) begin : g_map
        assign paddr = (cpu_addr[ADDR_W-1 -: 2] == 2'b10) ? {3'b000, cpu_addr[ADDR_W-4:0]} : cpu_addr;
    end else begin : g_pass
        assign paddr = cpu_addr;
    end

    assign cpu_stall = (state == REQ) || (state == WAIT) || (state == IDLE && cpu_en);

    // request lifecycle: latch once in IDLE, hold until accepted, wait for data, park in DONE while held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bus.req   <= 1'b0;
            bus.wr    <= 1'b0;
            bus.size  <= 2'd0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_en) begin
                    bus.wr    <= |cpu_wen;
                    bus.size  <= cpu_size;
                    bus.addr  <= paddr;
                    bus.wdata <= cpu_wdata;
                    bus.req   <= 1'b1;
                    state     <= REQ;
                end
                REQ: if (bus.addr_ok) begin
                    bus.req <= 1'b0;
                    state   <= bus.data_ok ? DONE : WAIT;
                    if (bus.data_ok && !bus.wr) cpu_rdata <= bus.rdata;
                end
                WAIT: if (bus.data_ok) begin
                    state <= DONE;
                    if (!bus.wr) cpu_rdata <= bus.rdata;
                end
                DONE: if (!cpu_hold) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sramlike_bridge.md
Name: sramlike_bridge

Overview:
- Converts the CPU core's single-cycle SRAM-style data port (en/wen/addr/wdata → rdata) into a stallable sram-like handshake bus (req/addr_ok/data_ok).
- Generalised in data width; optional kseg0/kseg1 address folding; transfer size comes from the core.
- Sits between the core's memory stage and the AXI/cache interconnect, one instance per port (instruction or data).
- Adds a stall/hold protocol so each CPU request is issued on the bus exactly once.

Parameters:
- ADDR_W, 32, address width (≥30 when MAP_EN=1).
- DATA_W, 32, data width; multiple of 8. STRB_W = DATA_W/8.
- MAP_EN, 1, 1 = fold kseg0/kseg1 (vaddr[31:30]==2'b10 → paddr = {3'b000, vaddr[28:0]}); 0 = pass-through.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- cpu_en  in  1  CPU request valid; held stable while cpu_stall=1.
- cpu_wen  in  STRB_W  byte write strobes; 0 = read.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_addr  in  ADDR_W  virtual byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_hold  in  1  pipeline held by another source; retains a finished result.
- cpu_rdata  out  DATA_W  read data, valid while in DONE.
- cpu_stall  out  1  stall request to the pipeline.
- bus_req  out  1  sram-like request.
- bus_wr  out  1  1 = write.
- bus_size  out  2  registered cpu_size.
- bus_addr  out  ADDR_W  physical address (mapped).
- bus_wdata  out  DATA_W  write data.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  response / write completion.
- bus_rdata  in  DATA_W  read response data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset (async, resetn=0) forces:
  - state = IDLE;
  - bus_req, bus_wr, bus_size, bus_addr, bus_wdata, cpu_rdata = 0;
  - cpu_stall = 0 (given cpu_en=0).
- IDLE, cpu_en=1:
  - at the clock edge, latch bus_wr = |cpu_wen, bus_size, mapped bus_addr and bus_wdata;
  - go to REQ.
- REQ:
  - bus_req=1 (registered, not combinational); bus_* outputs held constant;
  - addr_ok=1 → WAIT;
  - addr_ok=1 and data_ok=1 in the same cycle → DONE directly, capturing bus_rdata.
- WAIT:
  - bus_req=0;
  - data_ok=1 → DONE; cpu_rdata <= bus_rdata (reads only; writes leave cpu_rdata unchanged).
- DONE:
  - cpu_rdata held;
  - cpu_hold=1 → stay in DONE; no new bus request even though cpu_en=1;
  - cpu_hold=0 → IDLE. This is the cycle the pipeline advances.
- cpu_stall (combinational) = (state==REQ) | (state==WAIT) | (state==IDLE & cpu_en).
  - In DONE, cpu_stall=0.
- Minimum latency: read with addr_ok in the first REQ cycle and data_ok next cycle → cpu_stall high for 3 cycles (IDLE, REQ, WAIT), result visible in the 4th.
- cpu_en dropping (flush) in REQ/WAIT:
  - the issued transaction is not retracted;
  - the FSM completes the handshake, passes through DONE, and the result is discarded by the core;
  - cpu_stall stays 1 until DONE.
- Stray signals:
  - data_ok in IDLE/REQ (without addr_ok)/DONE is ignored;
  - addr_ok outside REQ is ignored.
- One outstanding transaction maximum.
- MAP_EN=1:
  - addresses with vaddr[31:30]==2'b10 are folded;
  - kuseg/kseg2/kseg3 pass unchanged.
- Reset during WAIT: return to IDLE; a late data_ok is ignored.

Test Plan:
- Word read at 0xBFC0_0000, addr_ok in 1st REQ cycle, data_ok 1 cycle later with 0x1234_5678 → bus_addr=0x1FC0_0000, bus_size=2, bus_wr=0, stall 3 cycles, cpu_rdata=0x1234_5678.
- Byte write, wen=4'b0100, addr 0x8000_0012, wdata 0x00AB_0000; addr_ok delayed 4 cycles → bus_req high 5 cycles, bus_addr=0x0000_0012, bus_wr=1, bus_size=0, fields stable throughout.
- Same-cycle addr_ok+data_ok → REQ→DONE directly; stall 2 cycles.
- cpu_hold=1 for 3 cycles in DONE with cpu_en=1 → exactly one bus_req pulse total, cpu_rdata stable, stall=0.
- cpu_en dropped during WAIT → stall stays 1 until data_ok; no second request; back to IDLE.
- resetn asserted in WAIT, data_ok arrives after release → all outputs 0, data_ok ignored, next request normal.
